// File: rtl/spgd_dither_seq_if.sv
// Bus between the SPGD update logic / DAC-ADC routing and the dither sequencer.
// The master side issues commands and supplies ADC samples; the slave side is
// the sequencer, which drives the DAC code, status and results.
`timescale 1ns/1ps
interface spgd_dither_seq_if #(
    parameter int ADC_WIDTH = 12,
    parameter int DAC_WIDTH = 14,
    parameter int SETTLE_W  = 16,
    parameter int AVG_LOG2  = 4
) ();
    logic                                 start;
    logic                                 abort;
    logic signed [DAC_WIDTH-1:0]          base;
    logic        [DAC_WIDTH-2:0]          delta;
    logic        [SETTLE_W-1:0]           settle;
    logic signed [ADC_WIDTH-1:0]          adc_in;
    logic signed [DAC_WIDTH-1:0]          dac_out;
    logic                                 busy;
    logic                                 done;
    logic signed [ADC_WIDTH+AVG_LOG2-1:0] j_plus;
    logic signed [ADC_WIDTH+AVG_LOG2-1:0] j_minus;
    logic signed [ADC_WIDTH+AVG_LOG2:0]   j_diff;

    modport master (
        output start, abort, base, delta, settle, adc_in,
        input  dac_out, busy, done, j_plus, j_minus, j_diff
    );

    modport slave (
        input  start, abort, base, delta, settle, adc_in,
        output dac_out, busy, done, j_plus, j_minus, j_diff
    );
endinterface

// File: rtl/spgd_dither_seq.sv
// One SPGD dither cycle: step the DAC to base+delta, settle, average N ADC
// samples, step to base-delta, settle, average again, restore base and
// publish both sums and their difference. All outputs are registered.
`timescale 1ns/1ps
module spgd_dither_seq #(
    parameter int ADC_WIDTH = 12,
    parameter int DAC_WIDTH = 14,
    parameter int SETTLE_W  = 16,
    parameter int AVG_LOG2  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    spgd_dither_seq_if.slave   bus
);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

    typedef enum logic [2:0] {IDLE, WAIT_P, ACC_P, WAIT_M, ACC_M} state_t;

    state_t                      state_reg, state_next;
    logic signed [DAC_WIDTH-1:0] base_reg, base_next;
    logic        [DAC_WIDTH-2:0] delta_reg, delta_next;
    logic        [SETTLE_W-1:0]  settle_reg, settle_next;
    logic        [SETTLE_W-1:0]  cnt_reg, cnt_next;
    logic        [AVG_LOG2-1:0]  samp_reg, samp_next;
    logic signed [ACC_W-1:0]     acc_reg, acc_next;
    logic signed [ACC_W-1:0]     plus_reg, plus_next;
    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [ACC_W-1:0]     adc_ext;
    logic signed [DAC_WIDTH-1:0] dac_reg, dac_next;
    logic                        busy_reg, busy_next;
    logic                        done_reg, done_next;
    logic signed [ACC_W-1:0]     jp_reg, jp_next;
    logic signed [ACC_W-1:0]     jm_reg, jm_next;
    logic signed [ACC_W:0]       jd_reg, jd_next;

    // Sign-extend the ADC sample to accumulator width.
    assign adc_ext[ADC_WIDTH-1:0] = bus.adc_in;
    for (genvar gi = 0; gi < AVG_LOG2; gi++) begin : g_sext
        assign adc_ext[ADC_WIDTH+gi] = bus.adc_in[ADC_WIDTH-1];
    end

    // base +/- delta with one guard bit, clamped to the DAC code range.
    function automatic logic signed [DAC_WIDTH-1:0] dac_step(
        input logic signed [DAC_WIDTH-1:0] b,
        input logic        [DAC_WIDTH-2:0] d,
        input logic                        sub
    );
        logic signed [DAC_WIDTH:0] ext_b;
        logic signed [DAC_WIDTH:0] ext_d;
        logic signed [DAC_WIDTH:0] s;
        ext_b = {b[DAC_WIDTH-1], b};
        ext_d = {2'b00, d};
        s = sub ? (ext_b - ext_d) : (ext_b + ext_d);
        if (s[DAC_WIDTH] != s[DAC_WIDTH-1])
            dac_step = s[DAC_WIDTH] ? {1'b1, {(DAC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DAC_WIDTH-1){1'b1}}};
        else
            dac_step = s[DAC_WIDTH-1:0];
    endfunction

    // Next-state and datapath decisions; abort overrides everything outside IDLE.
    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        delta_next  = delta_reg;
        settle_next = settle_reg;
        cnt_next    = cnt_reg;
        samp_next   = samp_reg;
        acc_next    = acc_reg;
        plus_next   = plus_reg;
        dac_next    = dac_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        jp_next     = jp_reg;
        jm_next     = jm_reg;
        jd_next     = jd_reg;
        acc_sum     = acc_reg + adc_ext;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    base_next   = bus.base;
                    delta_next  = bus.delta;
                    settle_next = bus.settle;
                    dac_next    = dac_step(bus.base, bus.delta, 1'b0);
                    cnt_next    = bus.settle;
                    busy_next   = 1'b1;
                    state_next  = WAIT_P;
                end
            end
            WAIT_P, WAIT_M: begin
                if (cnt_reg == '0) begin
                    state_next = (state_reg == WAIT_P) ? ACC_P : ACC_M;
                    acc_next   = '0;
                    samp_next  = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ACC_P: begin
                acc_next  = acc_sum;
                samp_next = samp_reg + 1'b1;
                if (samp_reg == '1) begin
                    plus_next  = acc_sum;
                    dac_next   = dac_step(base_reg, delta_reg, 1'b1);
                    cnt_next   = settle_reg;
                    state_next = WAIT_M;
                end
            end
            ACC_M: begin
                acc_next  = acc_sum;
                samp_next = samp_reg + 1'b1;
                if (samp_reg == '1) begin
                    dac_next   = base_reg;
                    jp_next    = plus_reg;
                    jm_next    = acc_sum;
                    jd_next    = {plus_reg[ACC_W-1], plus_reg} - {acc_sum[ACC_W-1], acc_sum};
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (bus.abort && state_reg != IDLE) begin
            state_next = IDLE;
            dac_next   = base_reg;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            jp_next    = jp_reg;
            jm_next    = jm_reg;
            jd_next    = jd_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            delta_reg  <= '0;
            settle_reg <= '0;
            cnt_reg    <= '0;
            samp_reg   <= '0;
            acc_reg    <= '0;
            plus_reg   <= '0;
            dac_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            jp_reg     <= '0;
            jm_reg     <= '0;
            jd_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            base_reg   <= base_next;
            delta_reg  <= delta_next;
            settle_reg <= settle_next;
            cnt_reg    <= cnt_next;
            samp_reg   <= samp_next;
            acc_reg    <= acc_next;
            plus_reg   <= plus_next;
            dac_reg    <= dac_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            jp_reg     <= jp_next;
            jm_reg     <= jm_next;
            jd_reg     <= jd_next;
        end
    end

    assign bus.dac_out = dac_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.j_plus  = jp_reg;
    assign bus.j_minus = jm_reg;
    assign bus.j_diff  = jd_reg;
endmodule

// File: tb/tb_spgd_dither_seq.sv
// Bench for spgd_dither_seq: a cycle-count model of the dither sequence
// (edge numbers relative to the start edge) is compared against the DUT on
// every falling edge, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_spgd_dither_seq;
    localparam int ADC_WIDTH = 12;
    localparam int DAC_WIDTH = 14;
    localparam int SETTLE_W  = 16;
    localparam int AVG_LOG2  = 4;
    localparam int N         = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spgd_dither_seq_if #(.ADC_WIDTH(ADC_WIDTH), .DAC_WIDTH(DAC_WIDTH),
                         .SETTLE_W(SETTLE_W), .AVG_LOG2(AVG_LOG2)) bus ();

    spgd_dither_seq #(.ADC_WIDTH(ADC_WIDTH), .DAC_WIDTH(DAC_WIDTH),
                      .SETTLE_W(SETTLE_W), .AVG_LOG2(AVG_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_count  = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, got, want, $time);
        end
    endtask

    // ADC plant: either a level chosen by which DAC code is applied, or noise.
    logic noise = 1'b0;
    int   plant_code_p = 0;
    int   adc_p = 0;
    int   adc_m = 0;
    always @(negedge clk) begin
        if (noise)
            bus.adc_in = 12'($urandom);
        else if (int'(bus.dac_out) == plant_code_p)
            bus.adc_in = 12'(adc_p);
        else
            bus.adc_in = 12'(adc_m);
    end

    // Behavioural model: position in the cycle is an edge count k from start.
    logic signed [63:0] exp_dac = 0, exp_jp = 0, exp_jm = 0, exp_jd = 0;
    logic signed [63:0] exp_busy = 0, exp_done = 0;
    int     m_active = 0, m_k = 0, m_b = 0, m_d = 0, m_s = 0;
    longint m_sp = 0, m_sm = 0;

    function automatic int sat(input int v);
        if (v > 8191)  return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_dac = 0; exp_busy = 0; exp_done = 0;
            exp_jp = 0; exp_jm = 0; exp_jd = 0;
            m_active = 0; m_b = 0;
        end else begin
            exp_done = 0;
            if (m_active == 0) begin
                if (bus.start) begin
                    m_b = int'(bus.base);
                    m_d = int'(bus.delta);
                    m_s = int'(bus.settle);
                    m_k = 0; m_sp = 0; m_sm = 0;
                    m_active = 1;
                    exp_dac = sat(m_b + m_d);
                    exp_busy = 1;
                end
            end else begin
                m_k++;
                if (bus.abort) begin
                    m_active = 0;
                    exp_dac = m_b;
                    exp_busy = 0;
                end else begin
                    if (m_k >= m_s + 2 && m_k <= m_s + N + 1)
                        m_sp += longint'(bus.adc_in);
                    if (m_k == m_s + N + 1)
                        exp_dac = sat(m_b - m_d);
                    if (m_k >= 2 * m_s + N + 3 && m_k <= 2 * m_s + 2 * N + 2)
                        m_sm += longint'(bus.adc_in);
                    if (m_k == 2 * m_s + 2 * N + 2) begin
                        exp_dac = m_b;
                        exp_jp = m_sp; exp_jm = m_sm; exp_jd = m_sp - m_sm;
                        exp_done = 1; exp_busy = 0;
                        m_active = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("dac_out", bus.dac_out, exp_dac);
        check("busy",    bus.busy,    exp_busy);
        check("done",    bus.done,    exp_done);
        check("j_plus",  bus.j_plus,  exp_jp);
        check("j_minus", bus.j_minus, exp_jm);
        check("j_diff",  bus.j_diff,  exp_jd);
        if (bus.done) done_count++;
    end

    // Start a cycle and run it to done, checking edge-exact landmarks.
    task automatic run_cycle(input string tag, input int b, input int d, input int s,
                             input int want_plus, input int want_minus, input int want_l,
                             input bit pulse_start);
        int e;
        @(negedge clk);
        bus.base = 14'(b); bus.delta = 13'(d); bus.settle = 16'(s); bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        e = 0;
        check({tag, "_plus_code"}, bus.dac_out, want_plus);
        check({tag, "_busy_start"}, bus.busy, 1);
        while (!bus.done && e < 3000) begin
            if (e == 2) begin
                bus.base = 14'($urandom); bus.delta = 13'($urandom); bus.settle = 16'($urandom);
            end
            bus.start = (pulse_start && (e == 5 || e == 20)) ? 1'b1 : 1'b0;
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == s + N + 1) check({tag, "_minus_code"}, bus.dac_out, want_minus);
        end
        bus.start = 1'b0;
        check({tag, "_done_edge"}, e, want_l);
        check({tag, "_base_restored"}, bus.dac_out, b);
        $display("txn %s: done_edge=%0d j_plus=%0d j_minus=%0d j_diff=%0d",
                 tag, e, bus.j_plus, bus.j_minus, bus.j_diff);
        @(negedge clk);
        check({tag, "_done_width"}, bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        bus.start = 1'b0; bus.abort = 1'b0; bus.base = '0; bus.delta = '0; bus.settle = '0;
        repeat (3) @(negedge clk);
        check("rst_dac", bus.dac_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_jdiff", bus.j_diff, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic cycle
        plant_code_p = 150; adc_p = 10; adc_m = -5;
        run_cycle("basic", 100, 50, 3, 150, 50, 40, 1'b0);
        check("basic_jplus", bus.j_plus, 160);
        check("basic_jminus", bus.j_minus, -80);
        check("basic_jdiff", bus.j_diff, 240);

        // Saturation
        plant_code_p = 8191; adc_p = 3; adc_m = 1;
        run_cycle("sat_hi", 8000, 500, 1, 8191, 7500, 36, 1'b0);
        check("sat_hi_jdiff", bus.j_diff, 32);
        plant_code_p = -7500; adc_p = -4; adc_m = 6;
        run_cycle("sat_lo", -8000, 500, 2, -7500, -8192, 38, 1'b0);
        check("sat_lo_jdiff", bus.j_diff, -160);

        // settle=0 with start pulses while busy, noisy ADC
        noise = 1'b1;
        dc = done_count;
        run_cycle("settle0", 0, 10, 0, 10, -10, 34, 1'b1);
        repeat (40) @(negedge clk);
        check("settle0_single_done", done_count - dc, 1);
        noise = 1'b0;

        // Extremes
        plant_code_p = 100; adc_p = -2048; adc_m = -2048;
        run_cycle("ext_neg", 0, 100, 1, 100, -100, 36, 1'b0);
        check("ext_neg_jplus", bus.j_plus, -32768);
        check("ext_neg_jminus", bus.j_minus, -32768);
        check("ext_neg_jdiff", bus.j_diff, 0);
        adc_p = 2047; adc_m = -2048;
        run_cycle("ext_span", 0, 100, 1, 100, -100, 36, 1'b0);
        check("ext_span_jdiff", bus.j_diff, 65520);

        // Abort during ACC_P (settle=2: ACC_P spans edges 4..19)
        plant_code_p = 230; adc_p = 7; adc_m = 2;
        dc = done_count;
        @(negedge clk);
        bus.base = 14'(200); bus.delta = 13'(30); bus.settle = 16'(2); bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_dac", bus.dac_out, 200);
        check("abort_busy", bus.busy, 0);
        check("abort_jplus_kept", bus.j_plus, 32752);
        check("abort_jdiff_kept", bus.j_diff, 65520);
        repeat (40) @(negedge clk);
        check("abort_no_done", done_count - dc, 0);
        $display("txn abort: dac_out=%0d busy=%0d", bus.dac_out, bus.busy);
        run_cycle("post_abort", 200, 30, 2, 230, 170, 38, 1'b0);
        check("post_abort_jdiff", bus.j_diff, 80);

        // Asynchronous reset mid-cycle with start held high
        plant_code_p = 150; adc_p = 10; adc_m = -5;
        @(negedge clk);
        bus.base = 14'(100); bus.delta = 13'(50); bus.settle = 16'(3); bus.start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dac", bus.dac_out, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_jplus", bus.j_plus, 0);
        check("arst_jdiff", bus.j_diff, 0);
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_idle_dac", bus.dac_out, 0);
        check("arst_idle_busy", bus.busy, 0);
        $display("txn reset: dac_out=%0d busy=%0d j_plus=%0d", bus.dac_out, bus.busy, bus.j_plus);
        run_cycle("post_reset", 100, 50, 3, 150, 50, 40, 1'b0);
        check("post_reset_jdiff", bus.j_diff, 240);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spgd_dither_seq.md
# spgd_dither_seq

Sequencer for one SPGD dither cycle on a single DAC/ADC channel pair. On `start` it drives the DAC to base+delta, waits a programmable settle time, and accumulates 2^AVG_LOG2 ADC samples. It then repeats the settle and accumulate steps at base−delta, restores base, and reports both sums and their difference. It sits between the SPGD update logic and the GPIO/DAC/ADC routing block: its output feeds one DAC channel and it reads the matching ADC channel.

## Interface
- ADC_WIDTH, 12, ADC sample width, two's complement
- DAC_WIDTH, 14, DAC code width, two's complement
- SETTLE_W, 16, settle counter width
- AVG_LOG2, 4, log2 of samples accumulated per phase (N = 2^AVG_LOG2)

- clk  in  1  sample/DAC clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a dither cycle; sampled in IDLE only
- abort  in  1  synchronous cancel of a running cycle
- base  in  DAC_WIDTH  signed operating point
- delta  in  DAC_WIDTH-1  unsigned dither amplitude
- settle  in  SETTLE_W  settle cycles after each DAC step
- adc_in  in  ADC_WIDTH  signed ADC sample
- dac_out  out  DAC_WIDTH  registered signed DAC code
- busy  out  1  cycle in progress
- done  out  1  one-cycle pulse, results valid
- j_plus  out  ADC_WIDTH+AVG_LOG2  signed sum for the +delta phase
- j_minus  out  ADC_WIDTH+AVG_LOG2  signed sum for the −delta phase
- j_diff  out  ADC_WIDTH+AVG_LOG2+1  signed j_plus − j_minus

## Operation
- States: IDLE, WAIT_P, ACC_P, WAIT_M, ACC_M.
- **IDLE:** dac_out holds the last latched base (0 after reset).
  - start=1 latches base, delta and settle.
  - It sets dac_out = sat(base+delta), loads the counter with settle, and moves to WAIT_P.
- **WAIT_P / WAIT_M:** if the counter is 0, move to ACC_x and clear the accumulator and sample counter. Otherwise decrement the counter.
- **ACC_P:** add sign-extended adc_in to the accumulator on each of N cycles.
  - On the Nth sample, store the full sum to an internal plus register.
  - Set dac_out = sat(base−delta), reload the counter with settle, and move to WAIT_M.
- **ACC_M:** same as ACC_P.
  - On the Nth sample, set dac_out = base and update j_plus, j_minus and j_diff together.
  - Pulse done and move to IDLE.
- **Saturation:** compute in DAC_WIDTH+1 bits, then clamp to [−2^(DAC_WIDTH−1), 2^(DAC_WIDTH−1)−1].
- **Accumulator width:** ADC_WIDTH+AVG_LOG2 bits; it cannot overflow.
- **j_diff:** computed with one extra bit; no overflow.
- **start while busy:** ignored and not queued.
- **Input changes mid-cycle:** base, delta and settle changes have no effect until the next start.
- **abort (any non-IDLE state):**
  - Next edge: dac_out = latched base, state IDLE, busy 0.
  - No done pulse; j_* keep their previous values.
- **abort and start together in IDLE:** start wins; abort has no effect in IDLE.
- **settle=0:** WAIT_x lasts exactly one cycle (the zero check), so total latency is constant-offset as below.

## Timing
- **Reset:** asserting rst_n=0 immediately forces state IDLE. All outputs go to 0: dac_out, busy, done, j_plus, j_minus, j_diff.
- **Edge numbering:** edge 0 samples start=1.
- **Start (edge 0):**
  - After edge 0: dac_out = plus code, busy=1.
- **Plus phase:**
  - WAIT_P occupies edges 1..S+1, where S = settle.
  - ACC_P samples adc_in at edges S+2..S+N+1.
  - After edge S+N+1: dac_out = minus code.
- **Minus phase:**
  - WAIT_M occupies edges S+N+2..2S+N+2.
  - ACC_M samples at edges 2S+N+3..2S+2N+2.
- **Completion:** after edge L = 2S+2N+2:
  - dac_out = base, j_* updated, done=1, busy=0.
  - done returns to 0 after edge L+1.
- **Back-to-back:** a new start may be sampled at edge L+1.
- **Outputs:** all registered; no combinational path from input to output.

## Test plan
- **Reset:** hold rst_n=0 mid-cycle with an active stimulus → all outputs go to 0 asynchronously and stay 0 until a start arrives after release.
- **Basic cycle:**
  - Stimulus: base=100, delta=50, settle=3, N=16; adc_in=10 while dac_out=150, adc_in=−5 while dac_out=50.
  - Required response: dac_out sequence 150 → 50 → 100; j_plus=160, j_minus=−80, j_diff=240; done at edge 40, exactly one cycle wide.
- **Saturation:**
  - base=8000, delta=500 → plus code 8191 and minus code 7500.
  - base=−8000, delta=500 → minus code −8192.
- **settle=0 and start while busy:**
  - settle=0 → done at edge 34.
  - start pulses during busy → ignored; exactly one done.
- **Abort:** base=200; abort in ACC_P → dac_out=200 on the next edge, busy=0, no done, j_* unchanged; a subsequent start completes normally.
- **Extremes:**
  - adc_in=−2048 for both phases → j_plus=j_minus=−32768, j_diff=0.
  - adc_in=2047 plus / −2048 minus → j_diff=65520.
